// File: rtl/register_dump_tx_pkg.sv
// Shared definitions for the register-file dump transmitter.
// FSM encoding, UART frame constants and byte-select helper.
package register_dump_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HEADER = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;

    localparam int DEF_CLKS_PER_BIT = 434;

    // Big-endian byte n of a word: n=0 is bits [31:24].
    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  n
    );
        logic [7:0] b;
        unique case (n)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/register_dump_tx_uart_tx.sv
// UART 8N1 transmitter with a ready/send handshake.
// ready is high while idle and in the final cycle of a stop bit.
module register_dump_tx_uart_tx
    import register_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    logic                  active;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic [3:0]            bitn;
    logic                  txd_q;

    // Accepting in the last stop-bit cycle keeps frames gap-free.
    assign ready = !active || (cnt == CNT_LAST && bitn == BIT_LAST);
    assign txd   = txd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            active <= 1'b0;
            shreg  <= '1;
            cnt    <= '0;
            bitn   <= '0;
            txd_q  <= STOP_BIT;
        end else begin
            txd_q <= active ? shreg[0] : STOP_BIT;
            if (send && ready) begin
                shreg  <= {STOP_BIT, data, START_BIT};
                cnt    <= '0;
                bitn   <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (bitn == BIT_LAST) begin
                        active <= 1'b0;
                    end else begin
                        bitn  <= bitn + 4'd1;
                        shreg <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/register_dump_tx.sv
// Walks register indices and streams a header plus each word
// (big-endian) out over UART 8N1.
module register_dump_tx
    import register_dump_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [4:0] FIRST_REG    = 5'd0,
    parameter logic [4:0] LAST_REG     = 5'd31,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  regIndex,
    input  logic [31:0] regData,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    logic [2:0]  state;
    logic [4:0]  idx;
    logic [1:0]  bytecnt;
    logic [31:0] word;
    logic        flush;
    logic        done_q;
    logic        tx_send;
    logic        tx_ready;
    logic [7:0]  tx_data;

    assign regIndex = idx;
    assign busy     = (state != ST_IDLE);
    assign done     = done_q;

    always_comb begin
        tx_send = (state == ST_HEADER) || (state == ST_SEND);
        tx_data = (state == ST_HEADER) ? HEADER_BYTE
                                       : word_byte(word, bytecnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= FIRST_REG;
            bytecnt <= '0;
            word    <= '0;
            flush   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_HEADER;
                end
                ST_HEADER: begin
                    if (tx_ready) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    word    <= regData;
                    bytecnt <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        bytecnt <= bytecnt + 2'd1;
                        if (bytecnt == 2'd3) begin
                            if (idx == LAST_REG) begin
                                state <= ST_FINISH;
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    // txd lags the shifter by one cycle, so wait one more
                    if (flush) begin
                        flush  <= 1'b0;
                        done_q <= 1'b1;
                        idx    <= FIRST_REG;
                        state  <= ST_IDLE;
                    end else if (tx_ready) begin
                        flush <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    register_dump_tx_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock(clock),
        .reset(reset),
        .send (tx_send),
        .data (tx_data),
        .ready(tx_ready),
        .txd  (txd)
    );

endmodule

// File: tb/tb_register_dump_tx.sv
// Bench for register_dump_tx: UART decoder plus register-file
// model; expected streams built from the register array.
module tb_register_dump_tx;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start1, start2;
    logic [4:0]  ri1, ri2;
    logic [31:0] rd1, rd2;
    logic        txd1, txd2, busy1, busy2, done1, done2;
    logic [31:0] x [32];
    logic        mon_sel;
    logic        line;

    logic [7:0] rxq  [$];
    logic [7:0] expq [$];
    int ferr;
    int dcount1, dcount2;
    int checks, errors;

    always #5 clock = ~clock;

    assign rd1  = x[ri1];
    assign rd2  = x[ri2];
    assign line = mon_sel ? txd2 : txd1;

    register_dump_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clock), .reset(reset), .start(start1),
        .regIndex(ri1), .regData(rd1), .txd(txd1),
        .busy(busy1), .done(done1)
    );

    register_dump_tx #(
        .CLKS_PER_BIT(CPB), .FIRST_REG(5'd2), .LAST_REG(5'd3)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .regIndex(ri2), .regData(rd2), .txd(txd2),
        .busy(busy2), .done(done2)
    );

    always @(negedge clock) begin
        if (done1 === 1'b1) dcount1++;
        if (done2 === 1'b1) dcount2++;
    end

    // Independent 8N1 receiver sampling mid-bit on the selected line
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (line === 1'b0) begin
                repeat (CPB / 2) @(negedge clock);
                b = '0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = line;
                end
                repeat (CPB) @(negedge clock);
                if (line !== 1'b1) ferr++;
                rxq.push_back(b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic init_regs();
        for (int i = 0; i < 32; i++) x[i] = 32'h1000_0000 + i;
    endtask

    function automatic void build_expected(input int first, input int last);
        expq.delete();
        expq.push_back(8'hA5);
        for (int r = first; r <= last; r++) begin
            expq.push_back(x[r][31:24]);
            expq.push_back(x[r][23:16]);
            expq.push_back(x[r][15:8]);
            expq.push_back(x[r][7:0]);
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (rxq[i] !== expq[i]) return i;
        if (rxq.size() != expq.size()) return n;
        return -1;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v;
        else start2 = v;
    endtask

    // Runs one dump; returns latency, start-fall-to-done cycles,
    // count of txd levels not a multiple of CPB, busy at done.
    task automatic do_dump(
        input  int   sel,
        input  bit   hold,
        input  int   repulse,
        output int   lat,
        output int   cyc,
        output int   werr,
        output logic busy_at_done
    );
        bit   seen;
        logic prev;
        int   run;
        lat = 0; cyc = 0; werr = 0; busy_at_done = 1'bx;
        @(negedge clock);
        set_start(sel, 1'b1);
        seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (!hold) set_start(sel, 1'b0);
            if (line === 1'b0) begin
                seen = 1; lat = k; break;
            end
        end
        if (!seen) return;
        prev = 1'b0; run = 1;
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clock);
            if (repulse != 0 && !hold)
                set_start(sel, (c >= repulse && c < repulse + 3));
            if (line !== prev) begin
                if (run % CPB != 0) werr++;
                run = 1; prev = line;
            end else begin
                run++;
            end
            if ((sel == 0 ? done1 : done2) === 1'b1) begin
                cyc = c;
                busy_at_done = (sel == 0) ? busy1 : busy2;
                break;
            end
        end
    endtask

    task automatic settle_after_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        rxq.delete();
        ferr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 0; start2 = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            checks++;
            if ({txd1, busy1, done1, ri1} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
                errors++;
                $display("FAIL reset_idle: got txd=%b busy=%b done=%b idx=%0d expected 1 0 0 0",
                         txd1, busy1, done1, ri1);
            end
            checks++;
            if ({txd2, busy2, ri2} !== {1'b1, 1'b0, 5'd2}) begin
                errors++;
                $display("FAIL reset_idle2: got txd=%b busy=%b idx=%0d expected 1 0 2",
                         txd2, busy2, ri2);
            end
        end
    endtask

    task automatic test_default_dump();
        int lat, cyc, werr, d0, fd;
        logic bd;
        init_regs();
        build_expected(0, 31);
        mon_sel = 0; rxq.delete(); ferr = 0; d0 = dcount1;
        do_dump(0, 0, 0, lat, cyc, werr, bd);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency: got %0d expected 3", lat);
        end
        checks++;
        if (cyc != 1290 * CPB) begin
            errors++;
            $display("FAIL dump_cycles: got %0d expected %0d", cyc, 1290 * CPB);
        end
        checks++;
        if (bd !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b expected 0", bd);
        end
        @(negedge clock);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b expected 0", done1);
        end
        checks++;
        if (dcount1 - d0 != 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", dcount1 - d0);
        end
        checks++;
        if (ri1 !== 5'd0) begin
            errors++;
            $display("FAIL idx_rewind: got %0d expected 0", ri1);
        end
        checks++;
        if (rxq.size() != 129) begin
            errors++;
            $display("FAIL byte_count: got %0d expected 129", rxq.size());
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL stream: first diff at %0d expected none", fd);
        end
        checks++;
        if (ferr != 0 || werr != 0) begin
            errors++;
            $display("FAIL framing: got ferr=%0d werr=%0d expected 0 0", ferr, werr);
        end
    endtask

    task automatic test_random_contents();
        int lat, cyc, werr, fd;
        logic bd;
        for (int i = 0; i < 32; i++) x[i] = $urandom;
        build_expected(0, 31);
        mon_sel = 0; rxq.delete(); ferr = 0;
        do_dump(0, 0, 0, lat, cyc, werr, bd);
        @(negedge clock);
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL random_stream: first diff at %0d expected none", fd);
        end
        checks++;
        if (werr != 0 || ferr != 0) begin
            errors++;
            $display("FAIL random_framing: got werr=%0d ferr=%0d expected 0 0", werr, ferr);
        end
        init_regs();
    endtask

    task automatic test_range();
        int lat, cyc, werr, fd;
        logic bd;
        init_regs();
        build_expected(2, 3);
        mon_sel = 1; rxq.delete(); ferr = 0;
        do_dump(1, 0, 0, lat, cyc, werr, bd);
        @(negedge clock);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL range_latency: got %0d expected 3", lat);
        end
        checks++;
        if (cyc != 90 * CPB) begin
            errors++;
            $display("FAIL range_cycles: got %0d expected %0d", cyc, 90 * CPB);
        end
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL range_stream: first diff at %0d size %0d expected none size 9",
                     fd, rxq.size());
        end
        checks++;
        if (ri2 !== 5'd2) begin
            errors++;
            $display("FAIL range_idx: got %0d expected 2", ri2);
        end
        mon_sel = 0;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_start_ignored();
        int lat, cyc, werr, fd, d0, nbusy;
        logic bd;
        init_regs();
        build_expected(0, 31);
        mon_sel = 0; rxq.delete(); ferr = 0; d0 = dcount1;
        do_dump(0, 1, 0, lat, cyc, werr, bd);
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL held_stream: first diff at %0d size %0d expected none",
                     fd, rxq.size());
        end
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: got busy=%b expected 1", busy1);
        end
        checks++;
        if (dcount1 - d0 != 1) begin
            errors++;
            $display("FAIL held_done: got %0d expected 1", dcount1 - d0);
        end
        start1 = 0;
        settle_after_reset();
        do_dump(0, 0, 2000, lat, cyc, werr, bd);
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL repulse_stream: first diff at %0d size %0d expected none",
                     fd, rxq.size());
        end
        nbusy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (busy1 === 1'b1) nbusy++;
        end
        checks++;
        if (nbusy != 0) begin
            errors++;
            $display("FAIL repulse_idle: got %0d busy cycles expected 0", nbusy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, cyc, werr, fd, d0;
        bit seen;
        logic bd;
        init_regs();
        mon_sel = 0; rxq.delete();
        @(negedge clock);
        start1 = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            start1 = 1'b0;
            if (txd1 === 1'b0) begin seen = 1; break; end
        end
        // Byte index 6 is x1[23:16]=00; land on its data bit 2
        repeat (40 * 6 + 13) @(negedge clock);
        checks++;
        if (!seen || txd1 !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_txd: got %b expected 0", txd1);
        end
        d0 = dcount1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({txd1, busy1, ri1} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL abort: got txd=%b busy=%b idx=%0d expected 1 0 0",
                     txd1, busy1, ri1);
        end
        reset = 1'b0;
        repeat (60) @(negedge clock);
        checks++;
        if (dcount1 != d0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses expected 0", dcount1 - d0);
        end
        rxq.delete(); ferr = 0;
        build_expected(0, 31);
        do_dump(0, 0, 0, lat, cyc, werr, bd);
        @(negedge clock);
        fd = first_diff();
        checks++;
        if (fd != -1 || cyc != 1290 * CPB) begin
            errors++;
            $display("FAIL after_abort: diff at %0d cycles %0d expected none %0d",
                     fd, cyc, 1290 * CPB);
        end
    endtask

    task automatic test_coherence();
        int lat, cyc, werr, fd;
        logic bd;
        init_regs();
        build_expected(0, 31);
        expq[21] = 8'hDE; expq[22] = 8'hAD;
        expq[23] = 8'hBE; expq[24] = 8'hEF;
        mon_sel = 0; rxq.delete(); ferr = 0;
        fork
            begin
                for (int k = 0; k < 3000; k++) begin
                    @(negedge clock);
                    if (ri1 === 5'd3) begin
                        x[5] = 32'hDEAD_BEEF;
                        break;
                    end
                end
            end
        join_none
        do_dump(0, 0, 0, lat, cyc, werr, bd);
        @(negedge clock);
        fd = first_diff();
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL coherence: first diff at %0d expected none", fd);
        end
        checks++;
        if (rxq.size() < 25 || {rxq[21], rxq[24]} !== 16'hDEEF) begin
            errors++;
            $display("FAIL x5_word: got size %0d expected DE..EF at 21..24", rxq.size());
        end
        checks++;
        if (werr != 0) begin
            errors++;
            $display("FAIL bit_width: got %0d bad levels expected 0", werr);
        end
        init_regs();
    endtask

    initial begin
        checks = 0; errors = 0; ferr = 0;
        dcount1 = 0; dcount2 = 0;
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; mon_sel = 1'b0;
        init_regs();
        test_reset();
        test_default_dump();
        test_random_contents();
        test_range();
        test_start_ignored();
        test_reset_mid();
        test_coherence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
